alu_exec: RTL

- Execute-stage unit directly downstream of alu_ctrl. It consumes the 4-bit alufunc code plus two operands and produces the ALU result and the branch decision.
- Single-cycle ops complete in 1 cycle.
- Shifts are iterative (1 bit/cycle) to save area for the FFT/IFFT datapath.
- Uses valid/ready handshakes on both sides so the pipeline can stall on multi-cycle shifts.

---
 rtl/alu_exec_pkg.sv | 27 ++
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec_comb.sv | 43 ++++
 rtl/alu_exec.sv | 90 +++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - alufunc codes and decode helpers shared by the execute stage
package alu_exec_pkg;

  localparam int XLEN_DEF = 32;
  localparam int SHW_DEF  = 5;

  // Same code points alu_ctrl drives; 14 and 15 are unassigned.
  localparam logic [3:0] ALU_PLUS = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;

  function automatic logic is_shift(input logic [3:0] f);
    return (f == ALU_SLL) || (f == ALU_SRL) || (f == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - op issue and result handshake bundle of the execute stage
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alufunc;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch_taken;

  modport master (
    output in_valid, alufunc, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, branch_taken
  );

  modport slave (
    input  in_valid, alufunc, op_a, op_b, out_ready,
    output in_ready, out_valid, result, branch_taken
  );

endinterface

// File: rtl/alu_exec_comb.sv
// rtl/alu_exec_comb.sv - single-cycle ALU results and branch condition
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      alufunc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            cond_o
);

  logic lt_s;
  logic lt_u;
  logic eq;

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq   = a_i == b_i;

  always_comb begin
    result_o = '0;
    cond_o   = 1'b0;
    case (alufunc_i)
      ALU_PLUS: result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      // Shifts start from the unshifted operand; the iteration lives in alu_exec.
      ALU_SLL, ALU_SRL, ALU_SRA: result_o = a_i;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_BEQ: begin cond_o = eq;    result_o = {{(XLEN-1){1'b0}}, eq};    end
      ALU_BNE: begin cond_o = !eq;   result_o = {{(XLEN-1){1'b0}}, !eq};   end
      ALU_BLT: begin cond_o = lt_s;  result_o = {{(XLEN-1){1'b0}}, lt_s};  end
      ALU_BGE: begin cond_o = !lt_s; result_o = {{(XLEN-1){1'b0}}, !lt_s}; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute stage: handshake FSM with 1-bit/cycle iterative shifter
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = SHW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  alu_exec_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            br_q, br_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      func_q, func_d;

  logic [XLEN-1:0] comb_result;
  logic            comb_cond;
  logic            accept;
  logic [SHW-1:0]  k;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .alufunc_i (bus.alufunc),
    .a_i       (bus.op_a),
    .b_i       (bus.op_b),
    .result_o  (comb_result),
    .cond_o    (comb_cond)
  );

  // DONE with a consuming downstream can take the next op in the same cycle.
  assign bus.in_ready     = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept           = bus.in_valid & bus.in_ready;
  assign k                = bus.op_b[SHW-1:0];
  assign bus.out_valid    = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.branch_taken = br_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    func_d   = func_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      case (func_q)
        ALU_SLL: result_d = {result_q[XLEN-2:0], 1'b0};
        ALU_SRL: result_d = {1'b0, result_q[XLEN-1:1]};
        default: result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
      endcase
      cnt_d = cnt_q - SHW'(1);
      if (cnt_q == SHW'(1)) state_d = DONE;
    end else if (accept) begin
      result_d = comb_result;
      br_d     = comb_cond;
      func_d   = bus.alufunc;
      if (is_shift(bus.alufunc) && (k != '0)) begin
        cnt_d   = k;
        state_d = SHIFT;
      end else begin
        state_d = DONE;
      end
    end else if ((state_q == DONE) && bus.out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      func_q   <= ALU_PLUS;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
    end
  end

endmodule
